// File: rtl/contador_mod.sv
// Parametrised up/down counter with programmable modulus, synchronous load,
// prescaled count enable, wrap/saturate mode and a registered terminal-count pulse.
module contador_mod #(
    parameter int unsigned NBITS    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             count_up,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic [NBITS-1:0] limit,
    input  logic             sat_mode,
    output logic [NBITS-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [NBITS-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             step;

    generate
        if (PRESCALE > 1) begin : g_presc
            localparam logic [PW-1:0] PsLast = PW'(PRESCALE - 1);
            logic [PW-1:0] presc_q, presc_d;

            always_comb begin
                presc_d = presc_q;
                if (load) begin
                    presc_d = '0;
                end else if (en) begin
                    presc_d = (presc_q == PsLast) ? '0 : presc_q + PW'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_d;
                end
            end

            assign step = en && !load && (presc_q == PsLast);
        end else begin : g_nopresc
            assign step = en && !load;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (step) begin
            if (count_up) begin
                if (count_q < limit) begin
                    count_d = count_q + NBITS'(1);
                end else if (!sat_mode) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end
            end else begin
                // A limit lowered below the current count pulls the count back into range.
                if (count_q > limit) begin
                    count_d = limit;
                end else if (count_q != '0) begin
                    count_d = count_q - NBITS'(1);
                end else if (!sat_mode) begin
                    count_d = limit;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q >= limit);
    assign at_min = (count_q == '0);

endmodule
